// File: rtl/abc_pulse_sequencer_pkg.sv
// Shared types and defaults for the a->b->c pulse sequencer.
package abc_seq_pkg;

  localparam int GAP_CYCLES_DEF = 2;
  localparam int CNT_W_DEF      = 8;
  localparam int DONE_CNT_W_DEF = 16;
  localparam int GAP_W          = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PA   = 3'd1,
    ST_PB   = 3'd2,
    ST_PC   = 3'd3,
    ST_GAP  = 3'd4
  } state_e;

  // Cycles from the start edge to the edge that raises done for an
  // uninterrupted run; a request of 0 triplets behaves as 1.
  function automatic int run_cycles(input int n, input int gap);
    int m;
    m = (n < 1) ? 1 : n;
    return 3 * m + gap * (m - 1);
  endfunction

endpackage

// File: rtl/abc_pulse_sequencer_if.sv
// Control/status bundle between a run requester and the pulse sequencer.
interface abc_seq_if #(
  parameter int CNT_W      = 8,
  parameter int DONE_CNT_W = 16
);
  logic                  start;
  logic [CNT_W-1:0]      repeat_cnt;
  logic                  abort;
  logic                  a;
  logic                  b;
  logic                  c;
  logic                  busy;
  logic                  done;
  logic [DONE_CNT_W-1:0] trip_count;

  modport master (
    output start, repeat_cnt, abort,
    input  a, b, c, busy, done, trip_count
  );

  modport slave (
    input  start, repeat_cnt, abort,
    output a, b, c, busy, done, trip_count
  );
endinterface

// File: rtl/abc_pulse_sequencer_gap_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module abc_gap_timer
  import abc_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [GAP_W-1:0] load_val,
  output logic             tc
);

  logic [GAP_W-1:0] cnt;

  // Load wins over counting; the count parks at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - GAP_W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/abc_pulse_sequencer.sv
// Emits N one-hot a/b/c triplets per start, separated by GAP_CYCLES idle
// cycles, with busy/done status and a saturating completed-triplet count.
//
// state | meaning
// IDLE  | waiting for start, all pulses low
// PA    | a high
// PB    | b high
// PC    | c high; exit edge counts the triplet
// GAP   | all pulses low for GAP_CYCLES cycles
module abc_pulse_sequencer
  import abc_seq_pkg::*;
#(
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int DONE_CNT_W = DONE_CNT_W_DEF
) (
  input logic     clk,
  input logic     rst_n,
  abc_seq_if.slave bus
);

  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_PA   = ST_PA;
  localparam logic [2:0] S_PB   = ST_PB;
  localparam logic [2:0] S_PC   = ST_PC;
  localparam logic [2:0] S_GAP  = ST_GAP;

  // The timer holds GAP_CYCLES-1 on entry so GAP lasts exactly GAP_CYCLES.
  localparam logic [GAP_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  logic [2:0]            state, state_nxt;
  logic [CNT_W-1:0]      rem;
  logic [DONE_CNT_W-1:0] trip;
  logic                  a_q, b_q, c_q, busy_q, done_q;
  logic                  gap_load, gap_tc;
  logic                  run_go, pc_exit, rem_last;

  assign run_go   = (state == S_IDLE) && bus.start && !bus.abort;
  assign pc_exit  = (state == S_PC) && !bus.abort;
  assign rem_last = (rem == CNT_W'(1));

  abc_gap_timer u_gap (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load),
    .en       (state == S_GAP),
    .load_val (GAP_LOAD),
    .tc       (gap_tc)
  );

  // Next-state logic; abort from any state returns to IDLE.
  always_comb begin
    state_nxt = state;
    gap_load  = 1'b0;
    case (state)
      S_IDLE: if (run_go) state_nxt = S_PA;
      S_PA:   state_nxt = S_PB;
      S_PB:   state_nxt = S_PC;
      S_PC: begin
        if (rem_last) begin
          state_nxt = S_IDLE;
        end else if (GAP_CYCLES == 0) begin
          state_nxt = S_PA;
        end else begin
          state_nxt = S_GAP;
          gap_load  = 1'b1;
        end
      end
      S_GAP:  if (gap_tc) state_nxt = S_PA;
      default: state_nxt = S_IDLE;
    endcase
    if (bus.abort) state_nxt = S_IDLE;
  end

  // State, registered outputs, repeat counter and saturating trip counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      rem    <= '0;
      trip   <= '0;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      c_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      a_q    <= (state_nxt == S_PA);
      b_q    <= (state_nxt == S_PB);
      c_q    <= (state_nxt == S_PC);
      busy_q <= (state_nxt != S_IDLE);
      done_q <= pc_exit && rem_last;
      if (run_go) begin
        rem <= (bus.repeat_cnt == '0) ? CNT_W'(1) : bus.repeat_cnt;
      end else if (pc_exit) begin
        rem <= rem - CNT_W'(1);
      end
      if (pc_exit && trip != '1) begin
        trip <= trip + DONE_CNT_W'(1);
      end
    end
  end

  assign bus.a          = a_q;
  assign bus.b          = b_q;
  assign bus.c          = c_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.trip_count = trip;

endmodule

// File: doc/abc_pulse_sequencer.md
Name: abc_pulse_sequencer

Overview:
- Synthesizable stimulus source that drives the a→b→c one-hot pulse train consumed by the sequence-checking assertion stage, i.e. the property `a ##1 b |-> ##1 c`.
- On a start request it emits a configurable number of a/b/c triplets, separated by a programmable idle gap.
- It reports busy/done status and keeps a count of completed triplets.
- It replaces the hand-written initial-block stimulus, so the checker stage can be exercised repeatably.

Parameters:
- GAP_CYCLES, 2, all-low cycles inserted between consecutive triplets (legal range 0..255).
- CNT_W, 8, width of the repeat request and of the internal repeat counter.
- DONE_CNT_W, 16, width of the completed-triplet counter.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- start  input  1  request to begin a run; honoured only in IDLE.
- repeat_cnt  input  CNT_W  number of triplets per run; sampled with start; 0 is treated as 1.
- abort  input  1  terminates the run at the next edge.
- a  output  1  first pulse of the triplet.
- b  output  1  second pulse of the triplet.
- c  output  1  third pulse of the triplet.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a run completes normally.
- trip_count  output  DONE_CNT_W  total completed triplets since reset; saturating.

Behaviour:
- Reset: rst_n low at a posedge puts the block in IDLE and clears a, b, c, busy, done, trip_count and internal counters to 0. This applies from any state (mid-run included) and takes priority over start and abort.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, PA, PB, PC, GAP.
- IDLE:
  - start=1 at edge k loads rem = max(repeat_cnt, 1) and enters PA.
  - a=1 during the cycle after edge k; busy=1 from the same edge.
- PA→PB→PC, one cycle each, unconditional:
  - a is high after edge k, b after edge k+1, c after edge k+2.
  - Exactly one of a/b/c is high in these states; all are low in IDLE and GAP.
- Leaving PC at edge k+3:
  - trip_count increments unless already at all-ones, where it holds.
  - rem decrements.
  - If rem was 1: go to IDLE, done=1 for exactly that one cycle, busy=0.
  - Else if GAP_CYCLES=0: go straight to PA, giving back-to-back triplets with a immediately following c.
  - Else: go to GAP.
- GAP: stays exactly GAP_CYCLES cycles with a/b/c low, then goes to PA.
- start while busy: ignored; repeat_cnt is not re-sampled.
- start on the same edge that done is produced (PC→IDLE): ignored. A new run needs start sampled in IDLE, so the minimum spacing between runs is one IDLE cycle.
- abort=1 at any edge while busy:
  - Next state is IDLE; a/b/c/busy clear at that edge; done stays 0.
  - A triplet in flight is not counted.
  - An abort on the PC→ exit edge takes priority, so that triplet is not counted either.
- abort in IDLE: no effect. abort and start together in IDLE: abort wins, run not started.
- Latency: start edge k → first a high after edge k. A run of N triplets with gap G ends with done high after edge k + 3N + G(N−1).

Decomposition:
- Package abc_seq_pkg holds:
  - the state enum typedef (IDLE, PA, PB, PC, GAP);
  - default localparams for GAP_CYCLES, CNT_W, DONE_CNT_W;
  - a function returning the expected run length in cycles, for use by the bench.
- One natural sub-module: abc_gap_timer, a loadable down-counter with a terminal-count flag that is reused for the GAP state.
- The top level holds the FSM, the repeat counter and the saturating trip counter.

Test Plan:
- Single run: reset, start=1 with repeat_cnt=1 at edge 3 → a after edge 3, b after 4, c after 5, done=1 only after edge 6; trip_count=1; the attached assertion passes once.
- Multi run with gap: GAP_CYCLES=2, repeat_cnt=3, start at edge 2 → a at edges 2, 7, 12; done after edge 15; trip_count=3; a/b/c low in edges 5–6 and 10–11.
- Back-to-back: GAP_CYCLES=0, repeat_cnt=2 → a,b,c,a,b,c on consecutive cycles; done after the 6th pulse; repeat_cnt=0 behaves exactly as 1.
- Abort mid-run: repeat_cnt=4; abort asserted while b=1 in the 2nd triplet → all outputs 0 the next cycle; done never pulses; trip_count=1.
- Reset mid-run: rst_n=0 for one edge while c=1 → a/b/c/busy/done/trip_count all 0 after that edge; a start after reset releases runs normally.
- Ignored inputs: start pulsed while busy, and start on the done edge → no extra triplets, repeat_cnt not re-sampled. trip_count preset near all-ones (force) → saturates at 16'hFFFF.
